// File: rtl/instruction_aligner.sv
// Instruction aligner: turns a stream of 32-bit memory words into a stream of
// 16-bit (compressed) and 32-bit instructions at halfword-aligned PCs.
// Ports:
//   iCLK, iRST_N          clock, asynchronous active-low reset
//   iFLUSH, iFLUSH_PC     redirect pulse and byte target
//   oMEM_REQ, oMEM_ADDR   single-outstanding word read request
//   iMEM_VALID, iMEM_DATA read response (little-endian word)
//   oVALID, iREADY        instruction handshake
//   oIR, oIR_C, oIS_C     full instruction, head halfword, compressed flag
//   oPC                   byte address of the presented instruction
module instruction_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iFLUSH,
  input  logic [31:0] iFLUSH_PC,
  output logic        oMEM_REQ,
  output logic [31:0] oMEM_ADDR,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA,
  output logic        oVALID,
  input  logic        iREADY,
  output logic [31:0] oIR,
  output logic [15:0] oIR_C,
  output logic        oIS_C,
  output logic [31:0] oPC
);

  localparam int unsigned HW_W  = 16;
  localparam int unsigned BUF_W = 4 * HW_W;
  localparam int unsigned CNT_W = 3;

  logic [BUF_W-1:0] r_buf;      // halfword FIFO, head in bits [15:0]
  logic [CNT_W-1:0] r_cnt;      // buffered halfwords, 0..4
  logic [31:0]      r_pc;       // byte address of the head halfword
  logic [31:0]      r_faddr;    // next word address to fetch
  logic             r_outst;    // a read request has no response yet
  logic             r_discard;  // next response belongs to a flushed stream
  logic             r_skip;     // drop the low halfword of the next response
  logic             r_req;
  logic [31:0]      r_mem_addr;

  logic [HW_W-1:0]  w_head;
  logic             w_head_c;
  logic             w_avail;
  logic             w_accept;
  logic [1:0]       w_pop;
  logic             w_resp_ok;
  logic [1:0]       w_app;
  logic [BUF_W-1:0] w_app_data;
  logic [CNT_W-1:0] w_cnt_after_pop;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [BUF_W-1:0] w_buf_nxt;
  logic             w_req_go;
  logic             w_unused_flush_lsb;

  assign w_unused_flush_lsb = iFLUSH_PC[0];

  // Head decode: a 32-bit instruction needs two buffered halfwords.
  assign w_head   = r_buf[HW_W-1:0];
  assign w_head_c = (w_head[1:0] != 2'b11);
  assign w_avail  = w_head_c ? (r_cnt >= 3'd1) : (r_cnt >= 3'd2);
  assign w_accept = oVALID && iREADY;
  assign w_pop    = w_accept ? (w_head_c ? 2'd1 : 2'd2) : 2'd0;

  // Responses racing a flush, or owed to a flushed stream, are dropped.
  assign w_resp_ok  = iMEM_VALID && !iFLUSH && !r_discard;
  assign w_app      = w_resp_ok ? (r_skip ? 2'd1 : 2'd2) : 2'd0;
  assign w_app_data = r_skip ? {48'h0, iMEM_DATA[31:16]} : {32'h0, iMEM_DATA};

  // Pop shifts the head out; append lands just above the surviving entries.
  // Slots beyond the count are kept zero so OR-merging is safe.
  assign w_cnt_after_pop = r_cnt - CNT_W'(w_pop);
  assign w_cnt_nxt       = w_cnt_after_pop + CNT_W'(w_app);
  assign w_buf_nxt       = (r_buf >> {w_pop, 4'b0000}) |
                           (w_resp_ok ? (w_app_data << {w_cnt_after_pop, 4'b0000})
                                      : {BUF_W{1'b0}});

  // Request only when a full word is guaranteed to fit on arrival.
  assign w_req_go = !r_outst && !iFLUSH && (w_cnt_after_pop <= 3'd2);

  // State update; flush overrides any same-cycle accept or append.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_buf      <= '0;
      r_cnt      <= '0;
      r_pc       <= RESET_PC;
      r_faddr    <= RESET_PC;
      r_outst    <= 1'b0;
      r_discard  <= 1'b0;
      r_skip     <= 1'b0;
      r_req      <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      r_req <= w_req_go;
      if (w_req_go) begin
        r_mem_addr <= r_faddr;
      end
      if (iFLUSH) begin
        r_buf     <= '0;
        r_cnt     <= '0;
        r_pc      <= {iFLUSH_PC[31:1], 1'b0};
        r_faddr   <= {iFLUSH_PC[31:2], 2'b00};
        r_skip    <= iFLUSH_PC[1];
        r_discard <= r_outst && !iMEM_VALID;
        r_outst   <= r_outst && !iMEM_VALID;
      end else begin
        r_buf <= w_buf_nxt;
        r_cnt <= w_cnt_nxt;
        r_pc  <= r_pc + 32'({w_pop, 1'b0});
        if (w_req_go) begin
          r_faddr <= r_faddr + 32'd4;
        end
        if (w_resp_ok) begin
          r_skip <= 1'b0;
        end
        if (iMEM_VALID) begin
          r_outst   <= 1'b0;
          r_discard <= 1'b0;
        end else if (w_req_go) begin
          r_outst <= 1'b1;
        end
      end
    end
  end

  assign oMEM_REQ  = r_req;
  assign oMEM_ADDR = r_mem_addr;
  assign oVALID    = w_avail && !iFLUSH;
  assign oIR       = w_head_c ? {16'h0, w_head} : r_buf[31:0];
  assign oIR_C     = w_head;
  assign oIS_C     = w_head_c;
  assign oPC       = r_pc;

endmodule

// File: tb/tb_instruction_aligner.sv
`timescale 1ns/1ps
module tb_instruction_aligner;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        iCLK;
  logic        iRST_N;
  logic        iFLUSH;
  logic [31:0] iFLUSH_PC;
  logic        oMEM_REQ;
  logic [31:0] oMEM_ADDR;
  logic        iMEM_VALID;
  logic [31:0] iMEM_DATA;
  logic        oVALID;
  logic        iREADY;
  logic [31:0] oIR;
  logic [15:0] oIR_C;
  logic        oIS_C;
  logic [31:0] oPC;

  instruction_aligner #(.RESET_PC(RST_PC)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iFLUSH(iFLUSH), .iFLUSH_PC(iFLUSH_PC),
    .oMEM_REQ(oMEM_REQ), .oMEM_ADDR(oMEM_ADDR),
    .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA),
    .oVALID(oVALID), .iREADY(iREADY), .oIR(oIR), .oIR_C(oIR_C),
    .oIS_C(oIS_C), .oPC(oPC)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int          n_checks;
  int          n_fail;
  int          n_acc;
  int          fixed_lat;
  logic [31:0] mem_tab [logic [31:0]];
  // Reference model: architectural PC of next instruction, next fetch word.
  logic [31:0] m_pc;
  logic [31:0] m_faddr;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  bit          hold_prev;
  logic [31:0] prev_ir;
  logic [31:0] prev_pc;

  typedef struct {
    logic [31:0] fpc;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] exp_pc;
    logic [31:0] exp_ir;
    logic        exp_c;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] h;
    if (mem_tab.exists(a)) return mem_tab[a];
    h = (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
    return h ^ (h >> 15);
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at negedge, evaluate, advance the model.
  task automatic do_cycle(input bit flush, input logic [31:0] fpc, input bit rdy);
    logic [15:0] h0;
    logic [31:0] eir;
    bit          c;
    bit          resp_now;
    @(negedge iCLK);
    resp_now   = 1'b0;
    iMEM_VALID = 1'b0;
    iMEM_DATA  = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        iMEM_VALID = 1'b1;
        iMEM_DATA  = word_at(pend_addr);
        pend       = 1'b0;
        resp_now   = 1'b1;
      end
    end
    iFLUSH    = flush;
    iFLUSH_PC = fpc;
    iREADY    = rdy;
    #1;
    if (oMEM_REQ) begin
      chk("req_single_outstanding", 32'(pend | resp_now), 32'd0);
      chk("mem_addr", oMEM_ADDR, m_faddr);
      m_faddr   = m_faddr + 32'd4;
      pend      = 1'b1;
      pend_cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
      pend_addr = oMEM_ADDR;
    end
    if (flush) begin
      chk("flush_hides_valid", 32'(oVALID), 32'd0);
    end else if (hold_prev) begin
      chk("stall_valid", 32'(oVALID), 32'd1);
      chk("stall_ir", oIR, prev_ir);
      chk("stall_pc", oPC, prev_pc);
    end
    if (oVALID && rdy) begin
      h0 = hw_at(m_pc);
      c  = (h0[1:0] != 2'b11);
      eir = c ? {16'h0, h0} : {hw_at(m_pc + 32'd2), h0};
      chk("acc_pc", oPC, m_pc);
      chk("acc_ir", oIR, eir);
      chk("acc_ir_c", 32'(oIR_C), 32'(h0));
      chk("acc_is_c", 32'(oIS_C), 32'(c));
      m_pc = m_pc + (c ? 32'd2 : 32'd4);
      n_acc++;
    end
    hold_prev = oVALID && !rdy;
    prev_ir   = oIR;
    prev_pc   = oPC;
    if (flush) begin
      m_pc    = {fpc[31:1], 1'b0};
      m_faddr = {fpc[31:2], 2'b00};
    end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    do begin
      do_cycle(1'b0, 32'h0, 1'b0);
      k++;
    end while (!oVALID && k < 60);
    chk(name, 32'(oVALID), 32'd1);
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    #1;
    chk("reset_valid", 32'(oVALID), 32'd0);
    chk("reset_req", 32'(oMEM_REQ), 32'd0);
    chk("reset_pc", oPC, RST_PC);
    iFLUSH = 1'b0; iMEM_VALID = 1'b0; iREADY = 1'b0; iFLUSH_PC = '0; iMEM_DATA = '0;
    pend = 1'b0; hold_prev = 1'b0;
    m_pc = RST_PC; m_faddr = RST_PC;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    @(posedge iCLK);
    #1;
    chk("first_req", 32'(oMEM_REQ), 32'd1);
    chk("first_req_addr", oMEM_ADDR, RST_PC);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; n_acc = 0; fixed_lat = 0;
    vecs[0] = '{32'h0000_0200, 32'h00A0_0093, 32'h0001_0001, 32'h0000_0200, 32'h00A0_0093, 1'b0};
    vecs[1] = '{32'h0000_0202, 32'h4505_0000, 32'h0001_0001, 32'h0000_0202, 32'h0000_4505, 1'b1};
    vecs[2] = '{32'h0000_0302, 32'h0093_1234, 32'h0001_00A0, 32'h0000_0302, 32'h00A0_0093, 1'b0};
    vecs[3] = '{32'h0000_0401, 32'h0001_4581, 32'h0001_0001, 32'h0000_0400, 32'h0000_4581, 1'b1};
    vecs[4] = '{32'hFFFF_FFFC, 32'h1111_0003, 32'h0001_0001, 32'hFFFF_FFFC, 32'h1111_0003, 1'b0};
    vecs[5] = '{32'h0000_0506, 32'h0002_0000, 32'h0001_0001, 32'h0000_0506, 32'h0000_0002, 1'b1};

    iRST_N = 1'b0; iFLUSH = 1'b0; iFLUSH_PC = '0; iMEM_VALID = 1'b0;
    iMEM_DATA = '0; iREADY = 1'b0;
    #12;

    // Single 32-bit instruction after reset
    mem_tab[32'h0] = 32'h00A0_0093;
    mem_tab[32'h4] = 32'h0001_0001;
    do_reset();
    wait_valid("a_valid");
    chk("a_ir", oIR, 32'h00A0_0093);
    chk("a_is_c", 32'(oIS_C), 32'd0);
    chk("a_pc", oPC, 32'h0);
    do_cycle(1'b0, 32'h0, 1'b1);

    // Two compressed instructions from one word
    mem_tab[32'h0] = 32'h4505_4581;
    do_reset();
    wait_valid("b_valid0");
    chk("b_ir_c0", 32'(oIR_C), 32'h4581);
    chk("b_pc0", oPC, 32'h0);
    chk("b_is_c0", 32'(oIS_C), 32'd1);
    do_cycle(1'b0, 32'h0, 1'b1);
    wait_valid("b_valid1");
    chk("b_ir_c1", 32'(oIR_C), 32'h4505);
    chk("b_pc1", oPC, 32'h2);
    chk("b_is_c1", 32'(oIS_C), 32'd1);
    do_cycle(1'b0, 32'h0, 1'b1);

    // 32-bit instruction straddling two words
    fixed_lat = 3;
    mem_tab[32'h0] = 32'h0093_4501;
    mem_tab[32'h4] = 32'h1234_0A00;
    mem_tab[32'h8] = 32'h0001_0001;
    do_reset();
    wait_valid("c_valid0");
    chk("c_ir0", oIR, 32'h0000_4501);
    chk("c_pc0", oPC, 32'h0);
    do_cycle(1'b0, 32'h0, 1'b1);
    do_cycle(1'b0, 32'h0, 1'b1);
    chk("c_half_only_valid", 32'(oVALID), 32'd0);
    chk("c_half_only_head", 32'(oIR_C), 32'h0093);
    wait_valid("c_valid1");
    chk("c_ir1", oIR, 32'h0A00_0093);
    chk("c_pc1", oPC, 32'h2);
    chk("c_is_c1", 32'(oIS_C), 32'd0);
    do_cycle(1'b0, 32'h0, 1'b1);
    wait_valid("c_valid2");
    chk("c_ir2", oIR, 32'h0000_1234);
    chk("c_pc2", oPC, 32'h6);
    chk("c_is_c2", 32'(oIS_C), 32'd1);
    do_cycle(1'b0, 32'h0, 1'b1);

    // Full buffer stall, then asynchronous reset with three halfwords held
    fixed_lat = 1;
    mem_tab[32'h0] = 32'h4505_4581;
    mem_tab[32'h4] = 32'h0001_0001;
    do_reset();
    repeat (12) do_cycle(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, 32'h0, 1'b0);
      chk("full_no_req", 32'(oMEM_REQ), 32'd0);
      chk("full_ir_c", 32'(oIR_C), 32'h4581);
    end
    do_cycle(1'b0, 32'h0, 1'b1);
    do_cycle(1'b0, 32'h0, 1'b0);
    chk("three_no_req", 32'(oMEM_REQ), 32'd0);
    chk("pre_reset_valid", 32'(oVALID), 32'd1);
    #2;
    do_reset();
    do_cycle(1'b0, 32'h0, 1'b0);

    // Flush to a halfword-offset target with a request outstanding
    fixed_lat = 3;
    mem_tab[32'h0]   = 32'h0001_0001;
    mem_tab[32'h100] = 32'h4505_FFFF;
    mem_tab[32'h104] = 32'h0001_0001;
    do_reset();
    do_cycle(1'b0, 32'h0, 1'b0);
    do_cycle(1'b1, 32'h0000_0102, 1'b0);
    begin
      int k;
      k = 0;
      do begin
        do_cycle(1'b0, 32'h0, 1'b0);
        k++;
      end while (!oMEM_REQ && k < 20);
    end
    chk("e_req_seen", 32'(oMEM_REQ), 32'd1);
    chk("e_refetch_addr", oMEM_ADDR, 32'h100);
    wait_valid("e_valid");
    chk("e_pc", oPC, 32'h102);
    chk("e_ir", oIR, 32'h0000_4505);
    chk("e_is_c", 32'(oIS_C), 32'd1);
    do_cycle(1'b0, 32'h0, 1'b1);

    // Table of redirect targets and their first instruction
    fixed_lat = 0;
    for (int v = 0; v < 6; v++) begin
      mem_tab[{vecs[v].fpc[31:2], 2'b00}]         = vecs[v].w0;
      mem_tab[{vecs[v].fpc[31:2], 2'b00} + 32'd4] = vecs[v].w1;
      do_cycle(1'b1, vecs[v].fpc, 1'b0);
      wait_valid("tbl_valid");
      chk("tbl_pc", oPC, vecs[v].exp_pc);
      chk("tbl_ir", oIR, vecs[v].exp_ir);
      chk("tbl_is_c", 32'(oIS_C), 32'(vecs[v].exp_c));
      do_cycle(1'b0, 32'h0, 1'b1);
    end

    // Randomized traffic against the reference model
    mem_tab.delete();
    n_acc = 0;
    for (int i = 0; i < 3000; i++) begin
      bit f;
      bit r;
      f = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 9) < 7);
      do_cycle(f, 32'($urandom_range(0, 2047)), r);
    end
    chk("random_progress", 32'(n_acc > 300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_aligner.md
INSTRUCTION_ALIGNER -- requirements
Module: instruction_aligner

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 SHALL have port iCLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port iRST_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port iFLUSH  input  1  redirect request; one-cycle pulse.
REQ-005 SHALL have port iFLUSH_PC  input  32  redirect target, sampled when iFLUSH=1.
REQ-006 SHALL have port oMEM_REQ  output  1  one-cycle word-read request pulse.
REQ-007 SHALL have port oMEM_ADDR  output  32  word address, bits[1:0]=00, valid when oMEM_REQ=1.
REQ-008 SHALL have port iMEM_VALID  input  1  read data strobe, at least 1 cycle after oMEM_REQ.
REQ-009 SHALL have port iMEM_DATA  input  32  little-endian read word, valid with iMEM_VALID.
REQ-010 SHALL have port oVALID  output  1  oIR/oIR_C/oPC/oIS_C hold a complete instruction.
REQ-011 SHALL have port iREADY  input  1  downstream accepts the instruction when oVALID and iREADY are both 1.
REQ-012 SHALL have port oIR  output  32  full instruction; compressed case = {16'h0, halfword}.
REQ-013 SHALL have port oIR_C  output  16  lowest buffered halfword (always driven from buffer head).
REQ-014 SHALL have port oIS_C  output  1  1 when head halfword[1:0] != 2'b11.
REQ-015 SHALL have port oPC  output  32  byte address of the presented instruction.

Function
REQ-016 SHALL keep a halfword FIFO of capacity 4 (64 bits), with a 3-bit count of 0..4 and a head PC register.
REQ-017 SHALL assert oVALID combinationally when count>=1 and head[1:0]!=11, or when count>=2 and head[1:0]==11; count==1 with head[1:0]==11 SHALL give oVALID=0.
REQ-018 SHALL drive outputs for the 32-bit case as oIR={hw1,hw0}, oIR_C=hw0, oIS_C=0; for the compressed case as oIR={16'h0,hw0}, oIR_C=hw0, oIS_C=1.
REQ-019 SHALL, on accept, pop 1 halfword (compressed) or 2 halfwords (32-bit) and advance oPC by 2 or 4 respectively.
REQ-020 SHALL allow at most one outstanding memory request; SHALL pulse oMEM_REQ only when no request is outstanding, not flushing, and the count after any same-cycle pop is <=2.
REQ-021 SHALL increment the fetch address by 4 on each oMEM_REQ, wrapping modulo 2^32.
REQ-022 SHALL, on a non-discarded iMEM_VALID, append halfwords [15:0] then [31:16]; if the skip flag is set, append only [31:16] and clear the flag.
REQ-023 SHALL apply a pop and an append in the same cycle: new count = count - popped + appended.
REQ-024 SHALL, on iFLUSH, empty the FIFO, set head PC={iFLUSH_PC[31:1],1'b0}, set fetch address={iFLUSH_PC[31:2],2'b00}, set skip=iFLUSH_PC[1], and force oVALID=0 in that cycle.
REQ-025 SHALL, if a request is outstanding at iFLUSH, set a discard flag and drop the next iMEM_VALID; no new request SHALL issue until that response arrives.
REQ-026 SHALL drop an iMEM_VALID arriving in the same cycle as iFLUSH.
REQ-027 SHALL give iFLUSH priority over accept when both occur in the same cycle; the accept is void.
REQ-028 SHALL hold all outputs stable while oVALID=1 and iREADY=0.

Reset
REQ-029 SHALL, while iRST_N=0, force count=0, oVALID=0, oMEM_REQ=0, outstanding=0, discard=0, skip=0, head PC=RESET_PC, fetch address=RESET_PC.
REQ-030 SHALL issue the first oMEM_REQ (oMEM_ADDR=RESET_PC) on the first rising edge after iRST_N deasserts.

Verification
REQ-031 SHALL be covered by: reset release, word 0x00A00093 returned for 0x0 -> oVALID=1, oIR=0x00A00093, oIS_C=0, oPC=0x0.
REQ-032 SHALL be covered by: word 0x45054581 -> two accepts: (oIR_C=0x4581, oPC=0x0) then (oIR_C=0x4505, oPC=0x2), both with oIS_C=1.
REQ-033 SHALL be covered by a straddling fetch: words 0x00934501, 0x12340A00 -> 0x4501@0x0 (C), 0x0A000093@0x2 (32-bit), 0x1234@0x6 (C); oVALID=0 while only hw 0x0093 is buffered.
REQ-034 SHALL be covered by: iREADY=0 for 5 cycles with count=4 -> outputs stable and no oMEM_REQ until an accept occurs.
REQ-035 SHALL be covered by: iFLUSH with iFLUSH_PC=0x102 while a request is outstanding -> stale response dropped; next oMEM_ADDR=0x100; first output has oPC=0x102 from data[31:16].
REQ-036 SHALL be covered by: iRST_N asserted mid-stream with count=3 -> oVALID=0 immediately (asynchronously); after release, oMEM_ADDR=RESET_PC.
